uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares the single UART transmitter between NUM_REQ byte-stream requesters.
- Grants the TX to one requester per frame, where a frame is the bytes up to and including the one flagged LAST.
- Sequences each byte: one-cycle valid pulse into the TX, then waits for the TX busy to rise and fall.
- Sits between the system-side producers and UART_TX (P_DATA / Data_Valid / busy) inside the UART top level.

Parameters:
- DATA_WIDTH, 8, width of each byte/word sent to the UART TX.
- NUM_REQ, 4, number of requesters (2..8).
- BUSY_TIMEOUT, 16, cycles allowed from the valid pulse to busy rising (used only with UART_ARB_TIMEOUT_EN).

Ports:
- CLK  input  1  single clock, same domain as UART_TX.
- RST  input  1  asynchronous, active-low reset.
- REQ_VALID  input  NUM_REQ  per-requester byte valid.
- REQ_DATA  input  NUM_REQ*DATA_WIDTH  packed bytes; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- REQ_LAST  input  NUM_REQ  marks the final byte of a frame.
- REQ_READY  output  NUM_REQ  byte accepted when REQ_VALID[i] and REQ_READY[i] are both high at a rising edge.
- GRANT  output  NUM_REQ  one-hot owner of the TX; all zero when idle.
- TX_P_DATA  output  DATA_WIDTH  to UART_TX P_DATA.
- TX_DATA_VALID  output  1  to UART_TX Data_Valid; one-cycle pulse.
- TX_BUSY  input  1  from UART_TX busy.
- ACTIVE  output  1  high whenever state is not IDLE.
- TX_ERR  output  1  one-cycle pulse on busy timeout.

Behaviour:
- Interface: one clock, CLK. Reset RST is asynchronous and active-low.
- Reset values:
  - GRANT = 0, TX_P_DATA = 0, TX_DATA_VALID = 0, TX_ERR = 0, ACTIVE = 0.
  - Round-robin pointer = 0, so index 0 has highest priority first.
  - State = IDLE.
- Reset mid-frame: asserting RST mid-frame returns to the reset values immediately. The in-flight frame is abandoned and no further pulse is issued.
- Registered outputs: GRANT, TX_P_DATA, TX_DATA_VALID, TX_ERR, ACTIVE.
- REQ_READY is combinational: REQ_READY[i] = (state == SEND) & GRANT[i] & ~TX_BUSY.
- IDLE state:
  - Stay in IDLE while REQ_VALID == 0.
  - Otherwise select the first set REQ_VALID bit scanning ptr, ptr+1, … modulo NUM_REQ.
  - Next cycle: GRANT = one-hot of the selection, go to SEND.
- SEND state:
  - Wait for REQ_VALID[g] with TX_BUSY low. A gap in valid mid-frame holds the grant indefinitely.
  - On handshake:
    - TX_P_DATA <= REQ_DATA[g].
    - Latch REQ_LAST[g] into last_q.
    - TX_DATA_VALID = 1 for exactly the next cycle.
    - Go to WAIT_HI.
- WAIT_HI state: on TX_BUSY = 1, go to WAIT_LO.
- WAIT_LO state: on TX_BUSY = 0:
  - If last_q = 1, release: GRANT = 0, ptr = (g+1) mod NUM_REQ, go to IDLE.
  - Else go to SEND.
- TX_P_DATA hold: held stable from load until the next load. It never changes while TX_BUSY is high.
- Latency: REQ_VALID[i] rising with the arbiter idle at edge k gives:
  - GRANT at k+1.
  - Handshake at k+2, provided the requester holds valid.
  - TX_DATA_VALID high during cycle k+2 → k+3.
- Fairness:
  - A requester is never granted twice in a row while another requester has valid pending at release time.
  - Single requester: re-granted back-to-back, with one IDLE cycle between frames.
- Simultaneous requests in IDLE: the pointer decides; the lowest index is not favoured.
- A single-byte frame (LAST on the first byte) is legal.
- Requests arriving while busy: REQ_VALID on non-granted requesters is ignored until release and must be held by the requester.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(BUSY_TIMEOUT+1) starts in WAIT_HI.
  - If TX_BUSY has not risen after BUSY_TIMEOUT cycles, TX_ERR pulses for one cycle and the frame is aborted.
  - Abort means: GRANT = 0, ptr advances past the owner, go to IDLE.
  - The owner's remaining bytes wait for a new grant.
- Undefined: no counter; WAIT_HI waits forever; TX_ERR tied to 0. The port exists in both builds.

Test Plan:
- Reset, then REQ_VALID = 0010, REQ_DATA[1] = 0xA5, LAST = 1, TX model busy for 10 cycles after valid:
  - GRANT = 0010 at k+1, TX_DATA_VALID one pulse at k+2, TX_P_DATA = 0xA5.
  - GRANT back to 0 one cycle after busy falls.
- REQ_VALID = 1111 held continuously, each requester sending 1-byte frames:
  - Grant order 0, 1, 2, 3, 0, 1, … with no requester granted twice in a row.
- Requester 2 sends 3-byte frame 0x11, 0x22, 0x33 (LAST on 0x33) while requester 0 is also requesting:
  - All three bytes go out before GRANT moves to 0001.
  - Exactly 3 TX_DATA_VALID pulses, REQ_READY never high for requester 0 meanwhile.
- Assert RST while in WAIT_LO of byte 2 of a 3-byte frame:
  - All outputs at reset values immediately, no further TX_DATA_VALID.
  - The next grant goes to the lowest-index valid requester.
- Build with UART_ARB_TIMEOUT_EN, BUSY_TIMEOUT = 16, TX_BUSY stuck at 0:
  - TX_ERR pulses 16 cycles after the valid pulse, GRANT = 0 next cycle.
  - Without the macro, the arbiter stays in WAIT_HI and TX_ERR stays 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ framed byte streams.
// Optional busy-rise watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            REQ_VALID,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
    input  logic [NUM_REQ-1:0]            REQ_LAST,
    output logic [NUM_REQ-1:0]            REQ_READY,
    output logic [NUM_REQ-1:0]            GRANT,
    output logic [DATA_WIDTH-1:0]         TX_P_DATA,
    output logic                          TX_DATA_VALID,
    input  logic                          TX_BUSY,
    output logic                          ACTIVE,
    output logic                          TX_ERR
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

    state_t                  state_q, state_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [PW-1:0]           gidx_q, gidx_d;
    logic [PW-1:0]           ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    err_q, err_d;
    logic                    last_q, last_d;
    logic                    active_q;

    logic [2*NUM_REQ-1:0]    dbl_valid;
    logic [NUM_REQ-1:0]      rot_valid;
    logic                    sel_found;
    logic [PW-1:0]           sel_off;
    logic [PW:0]             sel_sum;
    logic [PW-1:0]           sel_idx;
    logic [PW-1:0]           next_ptr;
    logic [DATA_WIDTH-1:0]   cur_data;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);
    logic [CW-1:0]           cnt_q, cnt_d;
`endif

    assign cur_data  = REQ_DATA[gidx_q*DATA_WIDTH +: DATA_WIDTH];
    assign next_ptr  = (gidx_q == PW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
    assign REQ_READY = (state_q == SEND && !TX_BUSY) ? grant_q : '0;

    // Rotate the request vector so the pointer position becomes bit 0, then take the first set bit.
    always_comb begin
        dbl_valid = {REQ_VALID, REQ_VALID} >> ptr_q;
        rot_valid = dbl_valid[NUM_REQ-1:0];
        sel_found = 1'b0;
        sel_off   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!sel_found && rot_valid[i]) begin
                sel_found = 1'b1;
                sel_off   = PW'(i);
            end
        end
        sel_sum = {1'b0, ptr_q} + {1'b0, sel_off};
        sel_idx = (sel_sum >= (PW+1)'(NUM_REQ)) ? PW'(sel_sum - (PW+1)'(NUM_REQ)) : sel_sum[PW-1:0];
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        last_d  = last_q;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    grant_d = NUM_REQ'(1) << sel_idx;
                    gidx_d  = sel_idx;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (REQ_VALID[gidx_q] && !TX_BUSY) begin
                    data_d  = cur_data;
                    last_d  = REQ_LAST[gidx_q];
                    valid_d = 1'b1;
                    state_d = WAIT_HI;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            WAIT_HI: begin
                if (TX_BUSY) begin
                    state_d = WAIT_LO;
                end
`ifdef UART_ARB_TIMEOUT_EN
                // Transmitter never acknowledged the byte: drop the frame and move on.
                else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    grant_d = '0;
                    ptr_d   = next_ptr;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            WAIT_LO: begin
                if (!TX_BUSY) begin
                    if (last_q) begin
                        grant_d = '0;
                        ptr_d   = next_ptr;
                        state_d = IDLE;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            ptr_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            last_q   <= 1'b0;
            active_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            ptr_q    <= ptr_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            last_q   <= last_d;
            active_q <= (state_d != IDLE);
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign GRANT         = grant_q;
    assign TX_P_DATA     = data_q;
    assign TX_DATA_VALID = valid_q;
    assign TX_ERR        = err_q;
    assign ACTIVE        = active_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a simple UART_TX busy model.
module tb_uart_tx_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;

    logic            CLK = 1'b0;
    logic            RST;
    logic [NR-1:0]   REQ_VALID;
    logic [NR*DW-1:0] REQ_DATA;
    logic [NR-1:0]   REQ_LAST;
    logic [NR-1:0]   REQ_READY;
    logic [NR-1:0]   GRANT;
    logic [DW-1:0]   TX_P_DATA;
    logic            TX_DATA_VALID;
    logic            TX_BUSY;
    logic            ACTIVE;
    logic            TX_ERR;

    int tests_run    = 0;
    int tests_failed = 0;
    int busy_len     = 10;
    bit busy_stuck   = 1'b0;
    int busy_cnt;

    uart_tx_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BUSY_TIMEOUT(16)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA), .REQ_LAST(REQ_LAST), .REQ_READY(REQ_READY),
        .GRANT(GRANT), .TX_P_DATA(TX_P_DATA), .TX_DATA_VALID(TX_DATA_VALID), .TX_BUSY(TX_BUSY),
        .ACTIVE(ACTIVE), .TX_ERR(TX_ERR)
    );

    always #5 CLK = ~CLK;

    // Transmitter model: busy rises the edge after a valid pulse and stays high busy_len cycles.
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            TX_BUSY  <= 1'b0;
            busy_cnt <= 0;
        end else if (busy_stuck) begin
            TX_BUSY  <= 1'b0;
        end else if (TX_DATA_VALID) begin
            TX_BUSY  <= 1'b1;
            busy_cnt <= busy_len - 1;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            TX_BUSY  <= 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_byte(input int i, input logic [DW-1:0] b);
        REQ_DATA[i*DW +: DW] = b;
    endtask

    task automatic apply_reset();
        REQ_VALID = '0;
        REQ_DATA  = '0;
        REQ_LAST  = '0;
        RST       = 1'b0;
        repeat (2) step();
        RST = 1'b1;
    endtask

    task automatic test_reset();
        REQ_VALID = '0;
        REQ_DATA  = '0;
        REQ_LAST  = '0;
        RST       = 1'b0;
        step();
        tests_run++;
        if (GRANT !== 4'b0000) begin tests_failed++; $display("[TB] FAIL reset_grant: got %b expected %b", GRANT, 4'b0000); end
        tests_run++;
        if (TX_DATA_VALID !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b expected 0", TX_DATA_VALID); end
        tests_run++;
        if (TX_P_DATA !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_data: got %h expected 00", TX_P_DATA); end
        tests_run++;
        if (ACTIVE !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_active: got %b expected 0", ACTIVE); end
        tests_run++;
        if (TX_ERR !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err: got %b expected 0", TX_ERR); end
        RST = 1'b1;
        repeat (2) step();
        tests_run++;
        if (GRANT !== 4'b0000 || ACTIVE !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL idle_no_req: grant %b active %b expected 0000/0", GRANT, ACTIVE);
        end
    endtask

    task automatic test_single_byte();
        int n;
        int pulses;
        busy_len  = 10;
        REQ_VALID = 4'b0010;
        REQ_LAST  = 4'b0010;
        set_byte(1, 8'hA5);
        step();
        tests_run++;
        if (GRANT !== 4'b0010) begin tests_failed++; $display("[TB] FAIL single_grant: got %b expected 0010", GRANT); end
        tests_run++;
        if (REQ_READY !== 4'b0010 || TX_DATA_VALID !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL single_ready: ready %b valid %b expected 0010/0", REQ_READY, TX_DATA_VALID);
        end
        step();
        tests_run++;
        if (TX_DATA_VALID !== 1'b1 || TX_P_DATA !== 8'hA5) begin
            tests_failed++;
            $display("[TB] FAIL single_pulse: valid %b data %h expected 1/a5", TX_DATA_VALID, TX_P_DATA);
        end
        pulses    = 1;
        REQ_VALID = '0;
        REQ_LAST  = '0;
        step();
        n = 0;
        while (TX_BUSY && n < 50) begin
            if (TX_DATA_VALID) pulses++;
            step();
            n++;
        end
        tests_run++;
        if (n >= 50) begin tests_failed++; $display("[TB] FAIL single_busy_timeout: busy never fell, got %0d cycles expected <50", n); end
        tests_run++;
        if (GRANT !== 4'b0010 || TX_P_DATA !== 8'hA5) begin
            tests_failed++;
            $display("[TB] FAIL single_hold: grant %b data %h expected 0010/a5", GRANT, TX_P_DATA);
        end
        step();
        tests_run++;
        if (GRANT !== 4'b0000 || ACTIVE !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL single_release: grant %b active %b expected 0000/0", GRANT, ACTIVE);
        end
        tests_run++;
        if (pulses !== 1) begin tests_failed++; $display("[TB] FAIL single_pulse_count: got %0d expected 1", pulses); end
    endtask

    task automatic test_round_robin();
        int ng;
        int n;
        logic [NR-1:0] prev_g;
        logic [NR-1:0] exp_g;
        apply_reset();
        busy_len  = 3;
        REQ_VALID = 4'b1111;
        REQ_LAST  = 4'b1111;
        for (int i = 0; i < NR; i++) set_byte(i, 8'h40 + 8'(i));
        ng     = 0;
        n      = 0;
        prev_g = '0;
        while (ng < 8 && n < 400) begin
            step();
            n++;
            if (GRANT !== 4'b0000 && prev_g === 4'b0000) begin
                exp_g = 4'(1) << (ng % NR);
                tests_run++;
                if (GRANT !== exp_g) begin tests_failed++; $display("[TB] FAIL rr_order_%0d: got %b expected %b", ng, GRANT, exp_g); end
                ng++;
            end
            if (TX_DATA_VALID && ng > 0) begin
                tests_run++;
                if (TX_P_DATA !== 8'h40 + 8'((ng - 1) % NR)) begin
                    tests_failed++;
                    $display("[TB] FAIL rr_data_%0d: got %h expected %h", ng, TX_P_DATA, 8'h40 + 8'((ng - 1) % NR));
                end
            end
            prev_g = GRANT;
        end
        tests_run++;
        if (ng < 8) begin tests_failed++; $display("[TB] FAIL rr_timeout: got %0d grants expected 8", ng); end
        REQ_VALID = '0;
    endtask

    task automatic test_multi_byte();
        logic [DW-1:0] bytes [3];
        logic [NR-1:0] ready_pre;
        int bi;
        int pulses;
        int n;
        bit got0;
        bit ready0;
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        apply_reset();
        busy_len  = 4;
        REQ_VALID = 4'b0100;
        set_byte(2, bytes[0]);
        step();
        tests_run++;
        if (GRANT !== 4'b0100) begin tests_failed++; $display("[TB] FAIL multi_grant: got %b expected 0100", GRANT); end
        REQ_VALID[0] = 1'b1;
        REQ_LAST[0]  = 1'b1;
        set_byte(0, 8'h77);
        bi = 0; pulses = 0; n = 0; got0 = 0; ready0 = 0;
        while (!got0 && n < 200) begin
            ready_pre = REQ_READY;
            step();
            n++;
            if (ready_pre[2] && REQ_VALID[2]) begin
                bi++;
                if (bi < 3) begin
                    set_byte(2, bytes[bi]);
                    REQ_LAST[2] = (bi == 2);
                end else begin
                    REQ_VALID[2] = 1'b0;
                    REQ_LAST[2]  = 1'b0;
                end
            end
            if (TX_DATA_VALID) begin
                if (pulses < 3) begin
                    tests_run++;
                    if (TX_P_DATA !== bytes[pulses]) begin
                        tests_failed++;
                        $display("[TB] FAIL multi_byte_%0d: got %h expected %h", pulses, TX_P_DATA, bytes[pulses]);
                    end
                end
                pulses++;
            end
            if (GRANT === 4'b0001) got0 = 1;
            else if (REQ_READY[0]) ready0 = 1;
        end
        tests_run++;
        if (!got0) begin tests_failed++; $display("[TB] FAIL multi_next_grant: got %b expected 0001", GRANT); end
        tests_run++;
        if (pulses !== 3) begin tests_failed++; $display("[TB] FAIL multi_pulse_count: got %0d expected 3", pulses); end
        tests_run++;
        if (ready0) begin tests_failed++; $display("[TB] FAIL multi_ready0: got 1 expected 0 while frame owned by 2"); end
        REQ_VALID = '0;
        REQ_LAST  = '0;
    endtask

    task automatic test_reset_mid_frame();
        logic [DW-1:0] bytes [3];
        logic [NR-1:0] ready_pre;
        int bi;
        int pulses;
        int n;
        bytes[0] = 8'hAA; bytes[1] = 8'hBB; bytes[2] = 8'hCC;
        apply_reset();
        busy_len  = 6;
        REQ_VALID = 4'b0010;
        set_byte(1, bytes[0]);
        bi = 0; pulses = 0; n = 0;
        while (!(pulses == 2 && TX_BUSY) && n < 200) begin
            ready_pre = REQ_READY;
            step();
            n++;
            if (ready_pre[1] && REQ_VALID[1] && bi < 2) begin
                bi++;
                set_byte(1, bytes[bi]);
                REQ_LAST[1] = (bi == 2);
            end
            if (TX_DATA_VALID) pulses++;
        end
        tests_run++;
        if (n >= 200) begin tests_failed++; $display("[TB] FAIL midrst_reach: got %0d pulses expected 2", pulses); end
        step();
        tests_run++;
        if (ACTIVE !== 1'b1 || GRANT !== 4'b0010) begin
            tests_failed++;
            $display("[TB] FAIL midrst_pre: active %b grant %b expected 1/0010", ACTIVE, GRANT);
        end
        #2;
        RST = 1'b0;
        #1;
        tests_run++;
        if (GRANT !== 4'b0000 || ACTIVE !== 1'b0 || REQ_READY !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL midrst_async: grant %b active %b ready %b expected 0000/0/0000", GRANT, ACTIVE, REQ_READY);
        end
        tests_run++;
        if (TX_P_DATA !== 8'h00 || TX_DATA_VALID !== 1'b0 || TX_ERR !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_outputs: data %h valid %b err %b expected 00/0/0", TX_P_DATA, TX_DATA_VALID, TX_ERR);
        end
        REQ_VALID = 4'b1010;
        REQ_LAST  = 4'b1010;
        set_byte(3, 8'h5C);
        pulses = 0;
        repeat (3) begin
            step();
            if (TX_DATA_VALID) pulses++;
        end
        tests_run++;
        if (pulses !== 0) begin tests_failed++; $display("[TB] FAIL midrst_no_pulse: got %0d expected 0", pulses); end
        RST = 1'b1;
        step();
        tests_run++;
        if (GRANT !== 4'b0010) begin tests_failed++; $display("[TB] FAIL midrst_regrant: got %b expected 0010", GRANT); end
        REQ_VALID = '0;
        REQ_LAST  = '0;
    endtask

    task automatic test_busy_timeout();
        apply_reset();
        busy_stuck = 1'b1;
        REQ_VALID  = 4'b1000;
        REQ_LAST   = 4'b1000;
        set_byte(3, 8'h3C);
        step();
        step();
        tests_run++;
        if (TX_DATA_VALID !== 1'b1 || TX_P_DATA !== 8'h3C) begin
            tests_failed++;
            $display("[TB] FAIL to_pulse: valid %b data %h expected 1/3c", TX_DATA_VALID, TX_P_DATA);
        end
        REQ_VALID = '0;
        REQ_LAST  = '0;
        for (int n = 1; n <= 20; n++) begin
            step();
`ifdef UART_ARB_TIMEOUT_EN
            tests_run++;
            if (TX_ERR !== (n == 16)) begin
                tests_failed++;
                $display("[TB] FAIL to_err_c%0d: got %b expected %b", n, TX_ERR, (n == 16));
            end
            if (n == 17) begin
                tests_run++;
                if (GRANT !== 4'b0000 || ACTIVE !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL to_abort: grant %b active %b expected 0000/0", GRANT, ACTIVE);
                end
            end
`else
            tests_run++;
            if (TX_ERR !== 1'b0) begin tests_failed++; $display("[TB] FAIL to_err_c%0d: got %b expected 0", n, TX_ERR); end
`endif
        end
`ifndef UART_ARB_TIMEOUT_EN
        tests_run++;
        if (GRANT !== 4'b1000 || ACTIVE !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL to_stuck: grant %b active %b expected 1000/1", GRANT, ACTIVE);
        end
`endif
        busy_stuck = 1'b0;
        apply_reset();
    endtask

    initial begin
        RST       = 1'b0;
        REQ_VALID = '0;
        REQ_DATA  = '0;
        REQ_LAST  = '0;
        test_reset();
        test_single_byte();
        test_round_robin();
        test_multi_byte();
        test_reset_mid_frame();
        test_busy_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
